// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared types and constants for the I/O bus target controller
package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACK,
        ST_RELEASE
    } state_t;

    localparam logic [3:0] CTRL_SLOT = 4'hF;

    localparam logic [2:0] REG_IRQ_MASK = 3'd0;
    localparam logic [2:0] REG_IRQ_PEND = 3'd1;
    localparam logic [2:0] REG_ERR      = 3'd2;

    localparam int ERR_TIMEOUT_BIT  = 0;
    localparam int ERR_UNMAPPED_BIT = 1;
    localparam int ERR_SLOT_LSB     = 4;

endpackage

// File: rtl/io_bus_ctrl_regs.sv
// rtl/io_bus_ctrl_regs.sv - IRQ mask / sticky error registers, read mux and irq aggregation
module io_bus_ctrl_regs
    import io_bus_pkg::*;
#(
    parameter int NUM_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wr_en,
    input  logic [2:0]           i_idx,
    input  logic [1:0]           i_be,
    input  logic [15:0]          i_wdata,
    input  logic                 i_set_timeout,
    input  logic                 i_set_unmapped,
    input  logic [2:0]           i_timeout_slot,
    input  logic [NUM_SLOTS-1:0] i_slot_irq,
    output logic [15:0]          o_rdata,
    output logic                 o_irq
);

    logic [NUM_SLOTS-1:0] r_irq_mask;
    logic                 r_err_timeout;
    logic                 r_err_unmapped;
    logic [2:0]           r_err_slot;
    logic                 r_irq;
    logic [NUM_SLOTS-1:0] w_pend;
    logic                 w_err_wr;

    assign w_pend   = i_slot_irq & r_irq_mask;
    assign w_err_wr = i_wr_en && (i_idx == REG_ERR) && i_be[0];
    assign o_irq    = r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_mask     <= '0;
            r_err_timeout  <= 1'b0;
            r_err_unmapped <= 1'b0;
            r_err_slot     <= 3'd0;
            r_irq          <= 1'b0;
        end else begin
            r_irq <= |w_pend;
            if (i_wr_en && (i_idx == REG_IRQ_MASK) && i_be[0])
                r_irq_mask <= i_wdata[NUM_SLOTS-1:0];
            // A new error event takes precedence over a simultaneous clear
            if (i_set_timeout) begin
                r_err_timeout <= 1'b1;
                r_err_slot    <= i_timeout_slot;
            end else if (w_err_wr && i_wdata[ERR_TIMEOUT_BIT]) begin
                r_err_timeout <= 1'b0;
            end
            if (i_set_unmapped)
                r_err_unmapped <= 1'b1;
            else if (w_err_wr && i_wdata[ERR_UNMAPPED_BIT])
                r_err_unmapped <= 1'b0;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_idx)
            REG_IRQ_MASK: o_rdata = 16'(r_irq_mask);
            REG_IRQ_PEND: o_rdata = 16'(w_pend);
            REG_ERR: begin
                o_rdata[ERR_TIMEOUT_BIT]        = r_err_timeout;
                o_rdata[ERR_UNMAPPED_BIT]       = r_err_unmapped;
                o_rdata[ERR_SLOT_LSB +: 3]      = r_err_slot;
            end
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// rtl/io_bus_ctrl.sv - I/O bus target: slot decode, handshake FSM, timeout and acknowledge
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int          NUM_SLOTS      = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] ERR_DATA       = 16'hDEAD
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic [15:0]             io_address,
    input  logic                    io_bus_enable,
    input  logic                    io_rw,
    input  logic [1:0]              io_byte_enable,
    input  logic [15:0]             io_write_data,
    output logic [15:0]             io_read_data,
    output logic                    io_acknowledge,
    output logic                    io_irq,
    output logic [NUM_SLOTS-1:0]    slot_req,
    output logic [11:0]             slot_addr,
    output logic                    slot_rw,
    output logic [1:0]              slot_byte_enable,
    output logic [15:0]             slot_write_data,
    input  logic [NUM_SLOTS*16-1:0] slot_read_data,
    input  logic [NUM_SLOTS-1:0]    slot_ack,
    input  logic [NUM_SLOTS-1:0]    slot_irq
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_SLOTS-1:0] r_slot_req;
    logic [11:0]          r_slot_addr;
    logic                 r_slot_rw;
    logic [1:0]           r_slot_be;
    logic [15:0]          r_slot_wdata;
    logic [15:0]          r_rdata;
    logic                 r_ack;

    logic [NUM_SLOTS-1:0] w_dec;
    logic                 w_is_slot;
    logic                 w_is_ctrl;
    logic                 w_ack_sel;
    logic                 w_timeout;
    logic [15:0]          w_sel_rdata;
    logic [2:0]           w_sel_slot;
    logic                 w_new_txn;
    logic                 w_reg_wr;
    logic                 w_set_timeout;
    logic                 w_set_unmapped;
    logic [15:0]          w_reg_rdata;

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            w_dec[i] = (io_address[15:12] == 4'(i));
    end

    // r_slot_req is one-hot on the active slot, so it doubles as the lane select
    always_comb begin
        w_sel_rdata = '0;
        w_sel_slot  = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_slot_req[i]) begin
                w_sel_rdata = slot_read_data[16*i +: 16];
                w_sel_slot  = 3'(i);
            end
        end
    end

    assign w_is_slot      = |w_dec;
    assign w_is_ctrl      = (io_address[15:12] == CTRL_SLOT);
    assign w_ack_sel      = |(slot_ack & r_slot_req);
    assign w_timeout      = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_new_txn      = (r_state == ST_IDLE) && io_bus_enable;
    assign w_reg_wr       = w_new_txn && w_is_ctrl && !io_rw;
    assign w_set_unmapped = w_new_txn && !w_is_slot && !w_is_ctrl;
    assign w_set_timeout  = (r_state == ST_ACCESS) && io_bus_enable && !w_ack_sel && w_timeout;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_slot_req   <= '0;
            r_slot_addr  <= '0;
            r_slot_rw    <= 1'b0;
            r_slot_be    <= '0;
            r_slot_wdata <= '0;
            r_rdata      <= '0;
            r_ack        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus_enable) begin
                        r_slot_addr  <= io_address[11:0];
                        r_slot_rw    <= io_rw;
                        r_slot_be    <= io_byte_enable;
                        r_slot_wdata <= io_write_data;
                        r_cnt        <= '0;
                        if (w_is_slot) begin
                            r_slot_req <= w_dec;
                            r_state    <= ST_ACCESS;
                        end else begin
                            r_ack   <= 1'b1;
                            r_rdata <= !io_rw ? 16'h0000 : (w_is_ctrl ? w_reg_rdata : ERR_DATA);
                            r_state <= ST_ACK;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!io_bus_enable) begin
                        r_slot_req <= '0;
                        r_state    <= ST_IDLE;
                    end else if (w_ack_sel) begin
                        r_slot_req <= '0;
                        r_ack      <= 1'b1;
                        r_rdata    <= r_slot_rw ? w_sel_rdata : 16'h0000;
                        r_state    <= ST_ACK;
                    end else if (w_timeout) begin
                        r_slot_req <= '0;
                        r_ack      <= 1'b1;
                        r_rdata    <= r_slot_rw ? ERR_DATA : 16'h0000;
                        r_state    <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!io_bus_enable)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    io_bus_ctrl_regs #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_regs (
        .clk            (clk_clk),
        .rst_n          (reset_reset_n),
        .i_wr_en        (w_reg_wr),
        .i_idx          (io_address[3:1]),
        .i_be           (io_byte_enable),
        .i_wdata        (io_write_data),
        .i_set_timeout  (w_set_timeout),
        .i_set_unmapped (w_set_unmapped),
        .i_timeout_slot (w_sel_slot),
        .i_slot_irq     (slot_irq),
        .o_rdata        (w_reg_rdata),
        .o_irq          (io_irq)
    );

    assign io_read_data     = r_rdata;
    assign io_acknowledge   = r_ack;
    assign slot_req         = r_slot_req;
    assign slot_addr        = r_slot_addr;
    assign slot_rw          = r_slot_rw;
    assign slot_byte_enable = r_slot_be;
    assign slot_write_data  = r_slot_wdata;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb/tb_io_bus_ctrl.sv - directed self-checking bench for io_bus_ctrl
module tb_io_bus_ctrl;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [15:0] io_address = '0;
    logic        io_bus_enable = 1'b0;
    logic        io_rw = 1'b0;
    logic [1:0]  io_byte_enable = '0;
    logic [15:0] io_write_data = '0;
    logic [15:0] io_read_data;
    logic        io_acknowledge;
    logic        io_irq;
    logic [3:0]  slot_req;
    logic [11:0] slot_addr;
    logic        slot_rw;
    logic [1:0]  slot_byte_enable;
    logic [15:0] slot_write_data;
    logic [63:0] slot_read_data = '0;
    logic [3:0]  slot_ack = '0;
    logic [3:0]  slot_irq = '0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int ack_cnt = 0;

    io_bus_ctrl #(
        .NUM_SLOTS      (4),
        .TIMEOUT_CYCLES (16),
        .ERR_DATA       (16'hDEAD)
    ) dut (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .io_address       (io_address),
        .io_bus_enable    (io_bus_enable),
        .io_rw            (io_rw),
        .io_byte_enable   (io_byte_enable),
        .io_write_data    (io_write_data),
        .io_read_data     (io_read_data),
        .io_acknowledge   (io_acknowledge),
        .io_irq           (io_irq),
        .slot_req         (slot_req),
        .slot_addr        (slot_addr),
        .slot_rw          (slot_rw),
        .slot_byte_enable (slot_byte_enable),
        .slot_write_data  (slot_write_data),
        .slot_read_data   (slot_read_data),
        .slot_ack         (slot_ack),
        .slot_irq         (slot_irq)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc <= cyc + 1;
    always @(negedge clk_clk) if (io_acknowledge) ack_cnt <= ack_cnt + 1;

    task automatic start_txn(input logic [15:0] a, input logic rw, input logic [1:0] be, input logic [15:0] wd);
        @(negedge clk_clk);
        io_address     = a;
        io_rw          = rw;
        io_byte_enable = be;
        io_write_data  = wd;
        io_bus_enable  = 1'b1;
        t0             = cyc;
    endtask

    task automatic wait_ack(output bit ok, output int dl, output logic [15:0] d);
        ok = 1'b0;
        dl = -1;
        d  = 16'hxxxx;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk_clk);
            if (io_acknowledge) begin
                ok = 1'b1;
                dl = cyc - t0;
                d  = io_read_data;
            end
        end
    endtask

    task automatic end_txn;
        @(negedge clk_clk);
        io_bus_enable = 1'b0;
        repeat (2) @(negedge clk_clk);
    endtask

    task automatic bus_access(input logic [15:0] a, input logic rw, input logic [1:0] be,
                              input logic [15:0] wd, output bit ok, output int dl, output logic [15:0] d);
        start_txn(a, rw, be, wd);
        wait_ack(ok, dl, d);
        end_txn();
    endtask

    task automatic test_reset;
        #1;
        n_vec++;
        if ({io_acknowledge, io_irq, slot_req, io_read_data, slot_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ack=%b irq=%b req=%b rd=%h addr=%h expected all 0",
                     io_acknowledge, io_irq, slot_req, io_read_data, slot_addr);
        end
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
    endtask

    task automatic test_slot_read;
        int a0;
        a0 = ack_cnt;
        start_txn(16'h1010, 1'b1, 2'b11, 16'h0000);
        @(negedge clk_clk);
        n_vec++;
        if (slot_req !== 4'b0010 || slot_addr !== 12'h010) begin
            n_err++;
            $display("FAIL slot_req_addr: req=%b addr=%h expected 0010 010", slot_req, slot_addr);
        end
        repeat (3) @(negedge clk_clk);
        slot_read_data = {16'h4444, 16'h3333, 16'h1234, 16'h1111};
        slot_ack = 4'b0010;
        @(negedge clk_clk);
        slot_ack = 4'b0000;
        n_vec++;
        if (io_acknowledge !== 1'b1 || io_read_data !== 16'h1234 || (cyc - t0) != 5) begin
            n_err++;
            $display("FAIL slot_read_ack: ack=%b rd=%h delta=%0d expected 1 1234 5",
                     io_acknowledge, io_read_data, cyc - t0);
        end
        @(negedge clk_clk);
        n_vec++;
        if (slot_req !== 4'b0000 || io_read_data !== 16'h0000) begin
            n_err++;
            $display("FAIL slot_read_after: req=%b rd=%h expected 0000 0000", slot_req, io_read_data);
        end
        repeat (2) @(negedge clk_clk);
        io_bus_enable = 1'b0;
        repeat (3) @(negedge clk_clk);
        n_vec++;
        if (ack_cnt - a0 != 1) begin
            n_err++;
            $display("FAIL slot_read_once: acks=%0d expected 1", ack_cnt - a0);
        end
    endtask

    task automatic test_ctrl_regs;
        bit ok;
        int dl;
        logic [15:0] d;
        bus_access(16'hF000, 1'b0, 2'b01, 16'h0005, ok, dl, d);
        n_vec++;
        if (!ok || dl != 1 || d !== 16'h0000) begin
            n_err++;
            $display("FAIL mask_write: ok=%b delta=%0d rd=%h expected 1 1 0000", ok, dl, d);
        end
        bus_access(16'hF000, 1'b1, 2'b11, 16'h0000, ok, dl, d);
        n_vec++;
        if (!ok || dl != 1 || d !== 16'h0005) begin
            n_err++;
            $display("FAIL mask_read: ok=%b delta=%0d rd=%h expected 1 1 0005", ok, dl, d);
        end
        slot_irq = 4'b0111;
        bus_access(16'hF002, 1'b1, 2'b11, 16'h0000, ok, dl, d);
        n_vec++;
        if (!ok || d !== 16'h0005 || io_irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_pend: ok=%b rd=%h irq=%b expected 1 0005 1", ok, d, io_irq);
        end
        @(negedge clk_clk);
        slot_irq = 4'b0000;
        #1;
        n_vec++;
        if (io_irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_latency: irq=%b expected 1 before next edge", io_irq);
        end
        @(negedge clk_clk);
        n_vec++;
        if (io_irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_clear: irq=%b expected 0", io_irq);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int dl;
        logic [15:0] d;
        bus_access(16'h2000, 1'b1, 2'b11, 16'h0000, ok, dl, d);
        n_vec++;
        if (!ok || dl != 17 || d !== 16'hDEAD) begin
            n_err++;
            $display("FAIL timeout_ack: ok=%b delta=%0d rd=%h expected 1 17 dead", ok, dl, d);
        end
        bus_access(16'hF004, 1'b1, 2'b11, 16'h0000, ok, dl, d);
        n_vec++;
        if (d !== 16'h0021) begin
            n_err++;
            $display("FAIL timeout_err: rd=%h expected 0021", d);
        end
        bus_access(16'hF004, 1'b0, 2'b01, 16'h0001, ok, dl, d);
        bus_access(16'hF004, 1'b1, 2'b11, 16'h0000, ok, dl, d);
        n_vec++;
        if (d !== 16'h0020) begin
            n_err++;
            $display("FAIL err_w1c: rd=%h expected 0020", d);
        end
    endtask

    task automatic test_unmapped;
        bit ok;
        int dl;
        logic [15:0] d;
        start_txn(16'h9000, 1'b1, 2'b11, 16'h0000);
        wait_ack(ok, dl, d);
        n_vec++;
        if (!ok || dl != 1 || d !== 16'hDEAD || slot_req !== 4'b0000) begin
            n_err++;
            $display("FAIL unmapped_ack: ok=%b delta=%0d rd=%h req=%b expected 1 1 dead 0000",
                     ok, dl, d, slot_req);
        end
        end_txn();
        bus_access(16'hF004, 1'b1, 2'b11, 16'h0000, ok, dl, d);
        n_vec++;
        if (d !== 16'h0022) begin
            n_err++;
            $display("FAIL unmapped_err: rd=%h expected 0022", d);
        end
    endtask

    task automatic test_ack_on_timeout;
        bit ok;
        int dl;
        logic [15:0] d;
        bus_access(16'hF004, 1'b0, 2'b01, 16'h0003, ok, dl, d);
        start_txn(16'h0000, 1'b1, 2'b11, 16'h0000);
        repeat (16) @(negedge clk_clk);
        slot_read_data = {16'h4444, 16'h3333, 16'h2222, 16'hBEEF};
        slot_ack = 4'b0001;
        @(negedge clk_clk);
        slot_ack = 4'b0000;
        n_vec++;
        if (io_acknowledge !== 1'b1 || io_read_data !== 16'hBEEF) begin
            n_err++;
            $display("FAIL ack_at_expiry: ack=%b rd=%h expected 1 beef", io_acknowledge, io_read_data);
        end
        end_txn();
        bus_access(16'hF004, 1'b1, 2'b11, 16'h0000, ok, dl, d);
        n_vec++;
        if (d !== 16'h0020) begin
            n_err++;
            $display("FAIL ack_at_expiry_err: rd=%h expected 0020", d);
        end
    endtask

    task automatic test_abort;
        int a0;
        a0 = ack_cnt;
        start_txn(16'h3000, 1'b1, 2'b11, 16'h0000);
        @(negedge clk_clk);
        n_vec++;
        if (slot_req !== 4'b1000) begin
            n_err++;
            $display("FAIL abort_req: req=%b expected 1000", slot_req);
        end
        repeat (2) @(negedge clk_clk);
        io_bus_enable = 1'b0;
        @(negedge clk_clk);
        n_vec++;
        if (slot_req !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_drop: req=%b expected 0000", slot_req);
        end
        repeat (20) @(negedge clk_clk);
        n_vec++;
        if (ack_cnt != a0) begin
            n_err++;
            $display("FAIL abort_no_ack: acks=%0d expected 0", ack_cnt - a0);
        end
    endtask

    task automatic test_async_reset;
        int a0;
        bit ok;
        int dl;
        logic [15:0] d;
        a0 = ack_cnt;
        start_txn(16'h1ABC, 1'b1, 2'b11, 16'h0000);
        repeat (2) @(negedge clk_clk);
        #2;
        reset_reset_n = 1'b0;
        #1;
        n_vec++;
        if ({slot_req, slot_addr, slot_rw, io_acknowledge, io_read_data} !== '0) begin
            n_err++;
            $display("FAIL async_reset: req=%b addr=%h rw=%b ack=%b rd=%h expected all 0",
                     slot_req, slot_addr, slot_rw, io_acknowledge, io_read_data);
        end
        @(negedge clk_clk);
        io_bus_enable = 1'b0;
        reset_reset_n = 1'b1;
        repeat (20) @(negedge clk_clk);
        n_vec++;
        if (ack_cnt != a0) begin
            n_err++;
            $display("FAIL reset_no_ack: acks=%0d expected 0", ack_cnt - a0);
        end
        start_txn(16'h1020, 1'b1, 2'b11, 16'h0000);
        @(negedge clk_clk);
        slot_read_data = {16'h4444, 16'h3333, 16'h5A5A, 16'h1111};
        slot_ack = 4'b0010;
        wait_ack(ok, dl, d);
        slot_ack = 4'b0000;
        n_vec++;
        if (!ok || dl != 2 || d !== 16'h5A5A) begin
            n_err++;
            $display("FAIL after_reset_txn: ok=%b delta=%0d rd=%h expected 1 2 5a5a", ok, dl, d);
        end
        end_txn();
    endtask

    initial begin
        test_reset();
        test_slot_read();
        test_ctrl_regs();
        test_timeout();
        test_unmapped();
        test_ack_on_timeout();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
